board_io_conditioner: RTL

//   Parametrised front end between the DE-board pins and Project core logic.
//   - Generates the core reset: holds sys_reset_n low RST_HOLD cycles after RESET_N rises.
//   - Synchronises and debounces NKEYS push-buttons and NSW slide switches.
//   - Emits clean levels plus one-cycle press/release/change pulses.

---
 rtl/board_io_pkg.sv | 26 ++
 rtl/board_io_conditioner_debounce_chan.sv | 62 ++++++
 rtl/board_io_conditioner.sv | 90 +++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
`timescale 1ns/100ps
// Shared constants and helpers for the board pin front end.
package board_io_pkg;

  // Normalised key levels after the polarity stage: 1 means the button is down.
  localparam logic KEY_PRESSED  = 1'b1;
  localparam logic KEY_RELEASED = 1'b0;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_RST_HOLD        = 16;

  // Bits needed to hold 0..v-1; never less than 1 so counters stay legal.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >>> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/board_io_conditioner_debounce_chan.sv
`timescale 1ns/100ps
// One input channel: two-flop synchroniser, stable-count debouncer and
// registered rise/fall pulses.
module debounce_chan
  import board_io_pkg::*;
#(
  parameter int   CYCLES     = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic raw,
  input  logic en_pulse,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          pulse_ok;

  // A channel only earns pulses once it has been seen settled while the core
  // is running, so a pin already active at power-up reports its level silently.
  assign pulse_ok = en_pulse & armed;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_p0 <= INIT_LEVEL;
      sync_p1 <= INIT_LEVEL;
      cnt     <= '0;
      level   <= INIT_LEVEL;
      armed   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // p0 -> p1: metastability guard
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      armed   <= en_pulse & (armed | (sync_p1 == level));
      // p1 -> level: accept only after CYCLES consecutive disagreeing samples
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        rise  <= pulse_ok & sync_p1;
        fall  <= pulse_ok & ~sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/board_io_conditioner.sv
`timescale 1ns/100ps
// Board pin front end: core reset sequencer plus debounced keys and switches
// with one-cycle edge pulses for the processor core.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RST_HOLD        = DEF_RST_HOLD,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [NKEYS-1:0] KEY,
  input  logic [NSW-1:0]   SW,
  output logic             sys_reset_n,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NSW-1:0]   sw_level,
  output logic [NSW-1:0]   sw_change
);

  localparam int            HW        = clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [HW-1:0] HOLD_DONE = HW'(RST_HOLD);

  logic             rst_sync_p0;
  logic             rst_sync_p1;
  logic [HW-1:0]    hold_cnt;
  logic [NKEYS-1:0] key_norm;
  logic [NSW-1:0]   sw_rise;
  logic [NSW-1:0]   sw_fall;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
      hold_cnt    <= '0;
      sys_reset_n <= 1'b0;
    end else begin
      // p0 -> p1: release synchroniser
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
      // p1 -> hold counter: saturates so the core stays out of reset
      if (rst_sync_p1 && (hold_cnt != HOLD_DONE)) begin
        hold_cnt <= hold_cnt + HW'(1);
        if (hold_cnt == HOLD_LAST) sys_reset_n <= 1'b1;
      end
    end
  end

  // Keys are normalised to 1 = pressed before synchronising, so the released
  // reset value of the sync flops is KEY_RELEASED whatever the pin polarity.
  assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~KEY : KEY;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    debounce_chan #(
      .CYCLES     (DEBOUNCE_CYCLES),
      .INIT_LEVEL (KEY_RELEASED)
    ) u_chan (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .raw      (key_norm[i]),
      .en_pulse (sys_reset_n),
      .level    (key_level[i]),
      .rise     (key_press[i]),
      .fall     (key_release[i])
    );
  end

  for (genvar j = 0; j < NSW; j++) begin : g_sw
    debounce_chan #(
      .CYCLES     (DEBOUNCE_CYCLES),
      .INIT_LEVEL (1'b0)
    ) u_chan (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .raw      (SW[j]),
      .en_pulse (sys_reset_n),
      .level    (sw_level[j]),
      .rise     (sw_rise[j]),
      .fall     (sw_fall[j])
    );
  end

  assign sw_change = sw_rise | sw_fall;

endmodule
